// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: credit-gated word fetch over a req/ack port, PC-tagged FIFO to decode.
// Optional IPQ_STATS_EN adds saturating fetch/discard counters.
module instr_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'd212,
    parameter int          CNT_W    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    output logic             mem_req,
    output logic [31:0]      mem_addr,
    input  logic             mem_ack,
    input  logic [31:0]      mem_rdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_instr,
    output logic [CNT_W-1:0] occupancy
`ifdef IPQ_STATS_EN
    ,
    output logic [15:0]      fetch_count,
    output logic [15:0]      discard_count
`endif
);
    localparam int PTR_W = CNT_W - 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN} state_t;

    state_t           state_q;
    logic [31:0]      fetch_pc_q;
    logic             mem_req_q;
    logic [31:0]      mem_addr_q;
    logic [31:0]      pc_mem_q  [DEPTH];
    logic [31:0]      ins_mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop, credit;

    assign push    = (state_q == S_REQ) && mem_ack && !redirect_valid;
    assign pop     = (count_q != '0) && out_ready && !redirect_valid;
    assign count_d = redirect_valid ? '0 : count_q + CNT_W'(push) - CNT_W'(pop);
    // The request about to be issued reserves one slot, so a later push always fits.
    assign credit  = count_d < CNT_W'(DEPTH);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            mem_req_q  <= 1'b0;
            mem_addr_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]  <= '0;
                ins_mem_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            if (redirect_valid) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                if (push) begin
                    pc_mem_q[wr_ptr_q]  <= mem_addr_q;
                    ins_mem_q[wr_ptr_q] <= mem_rdata;
                    wr_ptr_q            <= wr_ptr_q + 1'b1;
                end
                if (pop)
                    rd_ptr_q <= rd_ptr_q + 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (redirect_valid) begin
                        state_q    <= S_REQ;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= redirect_pc;
                        fetch_pc_q <= redirect_pc;
                    end else if (credit) begin
                        state_q    <= S_REQ;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= fetch_pc_q;
                    end
                end
                S_REQ: begin
                    if (redirect_valid) begin
                        fetch_pc_q <= redirect_pc;
                        if (mem_ack) mem_addr_q <= redirect_pc;
                        else         state_q    <= S_DRAIN;
                    end else if (mem_ack) begin
                        fetch_pc_q <= mem_addr_q + 32'd1;
                        if (credit) begin
                            mem_addr_q <= mem_addr_q + 32'd1;
                        end else begin
                            state_q   <= S_IDLE;
                            mem_req_q <= 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    // Old request still in flight: keep address stable, only retarget fetch_pc.
                    if (redirect_valid) begin
                        fetch_pc_q <= redirect_pc;
                        if (mem_ack) begin
                            state_q    <= S_REQ;
                            mem_addr_q <= redirect_pc;
                        end
                    end else if (mem_ack) begin
                        state_q    <= S_REQ;
                        mem_addr_q <= fetch_pc_q;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign out_valid = (count_q != '0);
    assign out_pc    = pc_mem_q[rd_ptr_q];
    assign out_instr = ins_mem_q[rd_ptr_q];
    assign occupancy = count_q;

`ifdef IPQ_STATS_EN
    logic        ack_live, ack_drop;
    logic [16:0] fetch_sum, disc_sum;

    assign ack_live  = mem_ack && (state_q != S_IDLE);
    assign ack_drop  = mem_ack && ((state_q == S_DRAIN) || ((state_q == S_REQ) && redirect_valid));
    assign fetch_sum = {1'b0, fetch_count} + 17'(ack_live);
    assign disc_sum  = {1'b0, discard_count} + 17'(ack_drop)
                     + (redirect_valid ? 17'(count_q) : 17'd0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_count   <= '0;
            discard_count <= '0;
        end else begin
            fetch_count   <= fetch_sum[16] ? 16'hFFFF : fetch_sum[15:0];
            discard_count <= disc_sum[16]  ? 16'hFFFF : disc_sum[15:0];
        end
    end
`endif
endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Self-checking bench for instr_prefetch_queue: expected PCs are queued as fetches are acked
// and checked against the head as the core pops; control points are checked directly.
module tb_instr_prefetch_queue;
    logic        clk = 1'b0;
    logic        reset, redirect_valid, mem_req, mem_ack, out_valid, out_ready;
    logic [31:0] redirect_pc, mem_addr, mem_rdata, out_pc, out_instr;
    logic [2:0]  occupancy;
`ifdef IPQ_STATS_EN
    logic [15:0] fetch_count, discard_count;
`endif

    int          n_run  = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    logic [31:0] e;

    instr_prefetch_queue #(.DEPTH(4), .RESET_PC(32'd212), .CNT_W(3)) dut (
        .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
        .occupancy(occupancy)
`ifdef IPQ_STATS_EN
        , .fetch_count(fetch_count), .discard_count(discard_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return ~pc ^ 32'h1234_5678;
    endfunction

    assign mem_rdata = mem_ack ? instr_of(mem_addr) : 32'hDEAD_BEEF;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; mem_ack = 1'b0; out_ready = 1'b0;
        tick(); tick();
        exp_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        n_run++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req got %0h want 0", mem_req); end
        n_run++; if (mem_addr !== 32'd212) begin n_fail++; $display("FAIL reset_mem_addr got %0d want 212", mem_addr); end
        n_run++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0h want 0", out_valid); end
        n_run++; if (out_pc !== 32'd0 || out_instr !== 32'd0) begin n_fail++; $display("FAIL reset_out_data got %0h/%0h want 0/0", out_pc, out_instr); end
        n_run++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL reset_occupancy got %0d want 0", occupancy); end
`ifdef IPQ_STATS_EN
        n_run++; if (fetch_count !== 16'd0 || discard_count !== 16'd0) begin n_fail++; $display("FAIL reset_stats got %0d/%0d want 0/0", fetch_count, discard_count); end
`endif
    endtask

    task automatic test_stream();
        do_reset();
        mem_ack = 1'b1; out_ready = 1'b1; reset = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            n_run++; if (mem_req !== 1'b1 || mem_addr !== 32'(212 + i)) begin n_fail++; $display("FAIL stream_addr[%0d] got %0h/%0d want 1/%0d", i, mem_req, mem_addr, 212 + i); end
            if (i > 0) begin
                n_run++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d] got %0h want 1", i, out_valid); end
            end
            if (out_valid && out_ready && !redirect_valid) begin
                n_run++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL stream_pop unexpected pc %0d", out_pc); end
                else begin
                    e = exp_q.pop_front();
                    if (out_pc !== e || out_instr !== instr_of(e)) begin n_fail++; $display("FAIL stream_pop got %0d/%0h want %0d/%0h", out_pc, out_instr, e, instr_of(e)); end
                end
            end
            if (mem_req && mem_ack) exp_q.push_back(32'(212 + i));
            tick();
        end
        n_run++; if (occupancy !== 3'd1) begin n_fail++; $display("FAIL stream_occupancy got %0d want 1", occupancy); end
    endtask

    task automatic test_full();
        int          pushes;
        logic [31:0] nxt;
        do_reset();
        mem_ack = 1'b1; out_ready = 1'b0; reset = 1'b1;
        tick();
        pushes = 0; nxt = 32'd212;
        for (int c = 0; c < 12 && mem_req; c++) begin
            exp_q.push_back(nxt); nxt++; pushes++;
            tick();
        end
        n_run++; if (pushes != 4) begin n_fail++; $display("FAIL full_pushes got %0d want 4", pushes); end
        n_run++; if (occupancy !== 3'd4 || mem_req !== 1'b0) begin n_fail++; $display("FAIL full_stop got occ %0d req %0h want 4/0", occupancy, mem_req); end
        tick(); tick();
        n_run++; if (occupancy !== 3'd4 || mem_req !== 1'b0 || out_pc !== 32'd212) begin n_fail++; $display("FAIL full_hold got occ %0d req %0h pc %0d want 4/0/212", occupancy, mem_req, out_pc); end
        out_ready = 1'b1;
        if (out_valid && out_ready && !redirect_valid) begin
            n_run++;
            e = exp_q.pop_front();
            if (out_pc !== e || out_instr !== instr_of(e)) begin n_fail++; $display("FAIL full_pop got %0d want %0d", out_pc, e); end
        end
        tick();
        out_ready = 1'b0;
        n_run++; if (mem_req !== 1'b1 || mem_addr !== 32'd216 || occupancy !== 3'd3) begin n_fail++; $display("FAIL full_reissue got req %0h addr %0d occ %0d want 1/216/3", mem_req, mem_addr, occupancy); end
        exp_q.push_back(32'd216);
        tick();
        n_run++; if (occupancy !== 3'd4 || mem_req !== 1'b0) begin n_fail++; $display("FAIL full_refill got occ %0d req %0h want 4/0", occupancy, mem_req); end
        mem_ack = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (out_valid && out_ready && !redirect_valid) begin
                n_run++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL full_drain unexpected pc %0d", out_pc); end
                else begin
                    e = exp_q.pop_front();
                    if (out_pc !== e || out_instr !== instr_of(e)) begin n_fail++; $display("FAIL full_drain got %0d/%0h want %0d/%0h", out_pc, out_instr, e, instr_of(e)); end
                end
            end
            tick();
        end
        n_run++; if (out_valid !== 1'b0 || exp_q.size() != 0 || mem_req !== 1'b1 || mem_addr !== 32'd217) begin n_fail++; $display("FAIL full_end got valid %0h left %0d req %0h addr %0d want 0/0/1/217", out_valid, exp_q.size(), mem_req, mem_addr); end
    endtask

    task automatic test_redirect_drain();
        do_reset();
        mem_ack = 1'b0; out_ready = 1'b1; reset = 1'b1;
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        tick();
        redirect_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            n_run++; if (mem_req !== 1'b1 || mem_addr !== 32'd212) begin n_fail++; $display("FAIL drain_hold[%0d] got %0h/%0d want 1/212", c, mem_req, mem_addr); end
            if (c == 1) mem_ack = 1'b1;
            tick();
        end
        n_run++; if (mem_addr !== 32'h40 || mem_req !== 1'b1 || out_valid !== 1'b0 || occupancy !== 3'd0) begin n_fail++; $display("FAIL drain_restart got addr %0h req %0h valid %0h occ %0d want 40/1/0/0", mem_addr, mem_req, out_valid, occupancy); end
`ifdef IPQ_STATS_EN
        n_run++; if (discard_count !== 16'd1 || fetch_count !== 16'd1) begin n_fail++; $display("FAIL drain_stats got %0d/%0d want 1/1", fetch_count, discard_count); end
`endif
        out_ready = 1'b0;
        exp_q.push_back(32'h40);
        tick();
        mem_ack = 1'b0; out_ready = 1'b1;
        n_run++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL drain_first_valid got %0h want 1", out_valid); end
        if (out_valid && out_ready && !redirect_valid) begin
            n_run++;
            e = exp_q.pop_front();
            if (out_pc !== e || out_instr !== instr_of(e)) begin n_fail++; $display("FAIL drain_first_pc got %0h/%0h want %0h/%0h", out_pc, out_instr, e, instr_of(e)); end
        end
        tick();
    endtask

    task automatic test_redirect_ack();
        do_reset();
        mem_ack = 1'b1; out_ready = 1'b0; reset = 1'b1;
        tick(); tick(); tick();
        n_run++; if (occupancy !== 3'd2) begin n_fail++; $display("FAIL rdack_pre_occ got %0d want 2", occupancy); end
        redirect_valid = 1'b1; redirect_pc = 32'h80; out_ready = 1'b1;
        tick();
        redirect_valid = 1'b0; out_ready = 1'b0;
        n_run++; if (occupancy !== 3'd0 || out_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h80) begin n_fail++; $display("FAIL rdack_flush got occ %0d valid %0h req %0h addr %0h want 0/0/1/80", occupancy, out_valid, mem_req, mem_addr); end
`ifdef IPQ_STATS_EN
        n_run++; if (discard_count !== 16'd3 || fetch_count !== 16'd3) begin n_fail++; $display("FAIL rdack_stats got %0d/%0d want 3/3", fetch_count, discard_count); end
`endif
        tick();
        n_run++; if (occupancy !== 3'd1 || out_pc !== 32'h80 || out_instr !== instr_of(32'h80)) begin n_fail++; $display("FAIL rdack_first got occ %0d pc %0h instr %0h want 1/80/%0h", occupancy, out_pc, out_instr, instr_of(32'h80)); end
    endtask

    task automatic test_wrap();
        do_reset();
        mem_ack = 1'b1; out_ready = 1'b1; reset = 1'b1;
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        tick();
        redirect_valid = 1'b0;
        n_run++; if (mem_addr !== 32'hFFFF_FFFF || out_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_a got %0h/%0h want ffffffff/0", mem_addr, out_valid); end
        tick();
        n_run++; if (mem_addr !== 32'h0 || out_pc !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_b got %0h/%0h want 0/ffffffff", mem_addr, out_pc); end
        tick();
        n_run++; if (mem_addr !== 32'h1 || out_pc !== 32'h0 || out_instr !== instr_of(32'h0)) begin n_fail++; $display("FAIL wrap_c got %0h/%0h/%0h want 1/0/%0h", mem_addr, out_pc, out_instr, instr_of(32'h0)); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        mem_ack = 1'b1; out_ready = 1'b0; reset = 1'b1;
        tick(); tick(); tick(); tick();
        mem_ack = 1'b0;
        tick();
        n_run++; if (mem_req !== 1'b1 || occupancy !== 3'd3 || mem_addr !== 32'd215) begin n_fail++; $display("FAIL rmid_pre got req %0h occ %0d addr %0d want 1/3/215", mem_req, occupancy, mem_addr); end
        reset = 1'b0;
        tick();
        n_run++; if (mem_req !== 1'b0 || out_valid !== 1'b0 || occupancy !== 3'd0 || mem_addr !== 32'd212) begin n_fail++; $display("FAIL rmid_post got req %0h valid %0h occ %0d addr %0d want 0/0/0/212", mem_req, out_valid, occupancy, mem_addr); end
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_redirect_drain();
        test_redirect_ack();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
